// File: rtl/snake_step_scheduler.sv
// Snake game sequencer: key edge detection, direction FIFO, game-state FSM and step divider.
// Optional macro SNAKE_SPEEDUP_EN shrinks the step divider as the game progresses.
module snake_step_scheduler #(
  parameter int DEPTH    = 4,
  parameter int DIV_W    = 4,
  parameter int TICK_DIV = 4
`ifdef SNAKE_SPEEDUP_EN
  ,
  parameter int SPEEDUP_STEPS = 16,
  parameter int MIN_DIV       = 1
`endif
) (
  input  logic       CLKBoard,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  input  logic       KEY_LEFT,
  input  logic       KEY_RIGHT,
  input  logic       KEY_S,
  input  logic       KEY_P,
  input  logic       KEY_R,
  input  logic       KEY_ESC,
  input  logic       COLLIDE,
  output logic [1:0] SNDIR,
  output logic       STEP,
  output logic [2:0] GAME_RUN,
  output logic       DROP
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      PTR_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]    IDX_ONE = PW'(1);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RUN   = 3'b001,
    S_PAUSE = 3'b010,
    S_OVER  = 3'b100
  } state_t;

  state_t state, state_next;

  // Valid/ready note: key edges are single-cycle requests with no back-pressure;
  // a request the FIFO cannot take is reported on DROP instead of stalling.
  logic [7:0] keys, key_hist, key_edge;
  logic e_up, e_down, e_left, e_right, e_s, e_p, e_r, e_esc;

  assign keys = {KEY_ESC, KEY_R, KEY_P, KEY_S, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};
  assign {e_esc, e_r, e_p, e_s, e_right, e_left, e_down, e_up} = key_edge;

  // History resets high so a key held through reset is not seen as a press.
  always_ff @(posedge CLKBoard) begin
    if (RESET) begin
      key_hist <= '1;
      key_edge <= '0;
    end else begin
      key_hist <= keys;
      key_edge <= keys & ~key_hist;
    end
  end

  always_ff @(posedge CLKBoard) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (e_r) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_RUN: begin
          if (e_esc)        state_next = S_OVER;
          else if (COLLIDE) state_next = S_OVER;
          else if (e_p)     state_next = S_PAUSE;
        end
        S_PAUSE: begin
          if (e_esc)    state_next = S_OVER;
          else if (e_p) state_next = S_RUN;
        end
        S_IDLE: begin
          if (e_s) state_next = S_RUN;
        end
        default: state_next = state;
      endcase
    end
  end

  logic dir_state_ok, run_stay, start_run;

  always_comb begin
    GAME_RUN     = state;
    dir_state_ok = ((state == S_RUN) || (state == S_PAUSE)) && !e_r;
    run_stay     = (state == S_RUN) && (state_next == S_RUN);
    start_run    = (state == S_IDLE) && (state_next == S_RUN);
  end

  // Direction FIFO
  logic [1:0]    mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [PW-1:0] tail_idx;
  logic          empty, full;
  logic          dir_req, reject, push_en, pop_en;
  logic [1:0]    dir_key, dir_ref;
  logic [1:0]    sndir_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign tail_idx = wr_ptr[PW-1:0] - IDX_ONE;

  always_comb begin
    dir_req = 1'b1;
    dir_key = 2'b00;
    if (e_up)         dir_key = 2'b00;
    else if (e_down)  dir_key = 2'b01;
    else if (e_left)  dir_key = 2'b10;
    else if (e_right) dir_key = 2'b11;
    else              dir_req = 1'b0;
  end

  // A key is judged against the last direction that will be applied before it.
  always_comb begin
    dir_ref = empty ? sndir_q : mem[tail_idx];
    reject  = full || (dir_key == dir_ref) || (dir_key == {dir_ref[1], ~dir_ref[0]});
    push_en = dir_state_ok && dir_req && !reject;
  end

  // Tick divider
  logic [DIV_W-1:0] cnt, div_last;
  logic             tick_hit, step_fire;

  assign tick_hit  = (state == S_RUN) && TICK && (cnt == div_last);
  assign step_fire = tick_hit && run_stay;
  assign pop_en    = step_fire && !empty;

`ifdef SNAKE_SPEEDUP_EN
  localparam int SC_W = $clog2(SPEEDUP_STEPS) + 1;
  logic [DIV_W-1:0] div;
  logic [SC_W-1:0]  step_cnt;

  always_ff @(posedge CLKBoard) begin
    if (RESET || e_r) begin
      div      <= DIV_W'(TICK_DIV);
      step_cnt <= '0;
    end else if (step_fire) begin
      if (step_cnt == SC_W'(SPEEDUP_STEPS - 1)) begin
        step_cnt <= '0;
        if (div > DIV_W'(MIN_DIV)) div <= div - CNT_ONE;
      end else begin
        step_cnt <= step_cnt + SC_W'(1);
      end
    end
  end

  assign div_last = div - CNT_ONE;
`else
  assign div_last = DIV_W'(TICK_DIV - 1);
`endif

  always_ff @(posedge CLKBoard) begin
    if (RESET || e_r || start_run) begin
      cnt <= '0;
    end else if ((state == S_RUN) && TICK) begin
      if (cnt == div_last) cnt <= '0;
      else                 cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge CLKBoard) begin
    if (push_en) mem[wr_ptr[PW-1:0]] <= dir_key;
  end

  always_ff @(posedge CLKBoard) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sndir_q <= 2'b11;
      STEP    <= 1'b0;
      DROP    <= 1'b0;
    end else begin
      STEP <= step_fire;
      DROP <= dir_state_ok && dir_req && reject;
      if (e_r) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        sndir_q <= 2'b11;
      end else begin
        if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_en) begin
          sndir_q <= mem[rd_ptr[PW-1:0]];
          rd_ptr  <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  assign SNDIR = sndir_q;

endmodule
